// File: rtl/lut_cfg_pkg.sv
// Shared types and width helpers for the fracturable two-LUT config sequencer.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    WRITE  = 2'd3
  } state_e;

  // Two 2**inputs LUT halves plus the split/fracture bit on top.
  function automatic int cfg_width(input int inputs);
    return 2 * (2 ** inputs) + 1;
  endfunction

  function automatic int beat_count(input int cfg_w, input int in_w);
    return (cfg_w + in_w - 1) / in_w;
  endfunction

  function automatic int split_bit(input int cfg_w);
    return cfg_w - 1;
  endfunction

endpackage

// File: rtl/lut_cfg_assembler.sv
// Collects IN_W-wide beats into a CFG_W-bit word; o_word_full flags the beat that completes it.
module lut_cfg_assembler
  import lut_cfg_pkg::*;
#(
  parameter int CFG_W = cfg_width(4),
  parameter int IN_W  = 8,
  parameter int BEATS = beat_count(CFG_W, IN_W)
) (
  input  logic             i_cclk,
  input  logic             i_rst,
  input  logic             i_accept,
  input  logic [IN_W-1:0]  i_data,
  output logic [CFG_W-1:0] o_word_nxt,
  output logic             o_word_full
);

  localparam int CNT_W = $clog2(BEATS + 1);

  logic [CNT_W-1:0] r_count;
  logic [CFG_W-1:0] r_word;
  logic [CFG_W-1:0] w_word_nxt;

  // Each word bit belongs to exactly one (beat, lane); bits past CFG_W-1 simply have no home.
  for (genvar gi = 0; gi < CFG_W; gi++) begin : g_bit
    assign w_word_nxt[gi] = (i_accept && (r_count == CNT_W'(gi / IN_W)))
                            ? i_data[gi % IN_W] : r_word[gi];
  end

  assign o_word_full = i_accept && (r_count == CNT_W'(BEATS - 1));
  assign o_word_nxt  = w_word_nxt;

  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      r_count <= '0;
      r_word  <= '0;
    end else begin
      r_word <= w_word_nxt;
      if (i_accept) begin
        r_count <= o_word_full ? '0 : r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_cfg_sequencer.sv
// Config/runtime-write sequencer for one fracturable two-LUT cell.
// Optional readback shadow register enabled by LUT_CFG_READBACK_EN.
//
// state  | meaning
// IDLE   | ready for a beat; otherwise issue a pending runtime write
// LOAD   | collecting the remaining beats of a config word
// COMMIT | one-cycle cen/done with config_out updated
// WRITE  | one-cycle write_en/wr_ack to the addressed LUT half
module lut_cfg_sequencer
  import lut_cfg_pkg::*;
#(
  parameter  int INPUTS = 4,
  parameter  int IN_W   = 8,
  localparam int CFG_W  = cfg_width(INPUTS),
  localparam int BEATS  = beat_count(CFG_W, IN_W)
) (
  input  logic              i_cclk,
  input  logic              i_rst,
  input  logic [IN_W-1:0]   i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_wr_req,
  input  logic              i_wr_sel,
  input  logic              i_wr_data,
  output logic              o_wr_ack,
  output logic              o_cen,
  output logic [CFG_W-1:0]  o_config_out,
  output logic              o_write_en,
  output logic              o_write_lut_select,
  output logic              o_data_in,
  output logic              o_busy,
`ifdef LUT_CFG_READBACK_EN
  input  logic [INPUTS-1:0] i_rd_idx,
  output logic [CFG_W-1:0]  o_cfg_shadow,
`endif
  output logic              o_done
);

  state_e r_state, w_state_nxt;

  logic             r_in_ready, r_cen, r_done, r_busy;
  logic             r_write_en, r_wr_ack, r_wsel, r_wdata;
  logic [CFG_W-1:0] r_config;
  logic             w_accept, w_word_full;
  logic [CFG_W-1:0] w_word_nxt;

  assign w_accept = i_in_valid && r_in_ready;

  lut_cfg_assembler #(
    .CFG_W (CFG_W),
    .IN_W  (IN_W),
    .BEATS (BEATS)
  ) u_asm (
    .i_cclk      (i_cclk),
    .i_rst       (i_rst),
    .i_accept    (w_accept),
    .i_data      (i_in_data),
    .o_word_nxt  (w_word_nxt),
    .o_word_full (w_word_full)
  );

  // Config beats win over a runtime write; the requester keeps wr_req up until acked.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept)      w_state_nxt = w_word_full ? COMMIT : LOAD;
        else if (i_wr_req) w_state_nxt = WRITE;
      end
      LOAD:    if (w_word_full) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b1;
      r_cen      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_write_en <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_wsel     <= 1'b0;
      r_wdata    <= 1'b0;
      r_config   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == IDLE) || (w_state_nxt == LOAD);
      r_cen      <= (w_state_nxt == COMMIT);
      r_done     <= (w_state_nxt == COMMIT);
      r_busy     <= (w_state_nxt != IDLE);
      r_write_en <= (w_state_nxt == WRITE);
      r_wr_ack   <= (w_state_nxt == WRITE);
      r_wsel     <= (w_state_nxt == WRITE) ? i_wr_sel  : 1'b0;
      r_wdata    <= (w_state_nxt == WRITE) ? i_wr_data : 1'b0;
      if (w_state_nxt == COMMIT) r_config <= w_word_nxt;
    end
  end

`ifdef LUT_CFG_READBACK_EN
  localparam int SPLIT = split_bit(CFG_W);
  localparam int IDX_W = $clog2(CFG_W);

  logic [CFG_W-1:0] r_shadow;
  logic [IDX_W-1:0] w_sh_idx;

  // Upper half sits MEM_SIZE above the lower half, so {sel, idx} is the bit address.
  assign w_sh_idx = IDX_W'({r_wsel, i_rd_idx});

  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      r_shadow <= '0;
    end else if (w_state_nxt == COMMIT) begin
      r_shadow <= w_word_nxt;
    end else if (r_write_en && !r_shadow[SPLIT]) begin
      r_shadow[w_sh_idx] <= r_wdata;
    end
  end

  assign o_cfg_shadow = r_shadow;
`endif

  assign o_in_ready         = r_in_ready;
  assign o_cen              = r_cen;
  assign o_done             = r_done;
  assign o_busy             = r_busy;
  assign o_write_en         = r_write_en;
  assign o_wr_ack           = r_wr_ack;
  assign o_write_lut_select = r_wsel;
  assign o_data_in          = r_wdata;
  assign o_config_out       = r_config;

endmodule

// File: tb/tb_lut_cfg_sequencer.sv
// Directed self-checking bench for lut_cfg_sequencer (default 4-input, 8-bit beat build).
module tb_lut_cfg_sequencer;

  localparam int CFG_W = 33;
  localparam int IN_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic             in_valid, in_ready;
  logic             wr_req, wr_sel, wr_data, wr_ack;
  logic             cen, write_en, write_lut_select, data_in, busy, done;
  logic [CFG_W-1:0] config_out;
`ifdef LUT_CFG_READBACK_EN
  logic [3:0]       rd_idx;
  logic [CFG_W-1:0] cfg_shadow;
`endif

  int checks  = 0;
  int errors  = 0;
  int cen_cnt = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int first_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (cen) cen_cnt = cen_cnt + 1;
      if (cen && write_en) begin
        errors = errors + 1;
        $display("FAIL cen_write_overlap: cen=%0b write_en=%0b at cycle %0d, required not both 1", cen, write_en, cyc);
      end
    end
  end

  lut_cfg_sequencer dut (
    .i_cclk             (clk),
    .i_rst              (rst),
    .i_in_data          (in_data),
    .i_in_valid         (in_valid),
    .o_in_ready         (in_ready),
    .i_wr_req           (wr_req),
    .i_wr_sel           (wr_sel),
    .i_wr_data          (wr_data),
    .o_wr_ack           (wr_ack),
    .o_cen              (cen),
    .o_config_out       (config_out),
    .o_write_en         (write_en),
    .o_write_lut_select (write_lut_select),
    .o_data_in          (data_in),
    .o_busy             (busy),
`ifdef LUT_CFG_READBACK_EN
    .i_rd_idx           (rd_idx),
    .o_cfg_shadow       (cfg_shadow),
`endif
    .o_done             (done)
  );

  // Presents one beat and returns #1 after the edge that accepted it, leaving in_valid high.
  task automatic send_beat(input logic [7:0] d);
    logic acc;
    int   n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      errors++;
      $display("FAIL send_beat_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    acc_cyc = cyc;
  endtask

  task automatic load_word(input logic [39:0] w, input int gap_after, input int gap_len);
    for (int i = 0; i < 5; i++) begin
      send_beat(w[i*8 +: 8]);
      if (i == 0) first_cyc = acc_cyc;
      if (i == gap_after) begin
        in_valid = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          checks++;
          if ({busy, in_ready, cen} !== 3'b110) begin
            errors++;
            $display("FAIL gap_hold: busy/in_ready/cen=%b, required 110", {busy, in_ready, cen});
          end
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Call right after load_word: checks the commit cycle and the one after it.
  task automatic check_commit(input string name, input logic [CFG_W-1:0] exp, input int lat);
    int c0;
    c0 = cen_cnt;
    @(negedge clk);
    checks++;
    if ({cen, done, in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL %s_commit: cen/done/in_ready=%b, required 110", name, {cen, done, in_ready});
    end
    checks++;
    if (config_out !== exp) begin
      errors++;
      $display("FAIL %s_config: config_out=%h, required %h", name, config_out, exp);
    end
    checks++;
    if (cyc - first_cyc !== lat) begin
      errors++;
      $display("FAIL %s_latency: cen %0d cycles after first beat, required %0d", name, cyc - first_cyc, lat);
    end
    @(negedge clk);
    checks++;
    if ({cen, done, in_ready, busy} !== 4'b0010 || config_out !== exp) begin
      errors++;
      $display("FAIL %s_after: cen/done/in_ready/busy=%b config_out=%h, required 0010 and %h",
               name, {cen, done, in_ready, busy}, config_out, exp);
    end
    checks++;
    if (cen_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL %s_cen_count: %0d cen pulses, required 1", name, cen_cnt - c0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    wr_req = 1'b0; wr_sel = 1'b0; wr_data = 1'b0;
`ifdef LUT_CFG_READBACK_EN
    rd_idx = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cen, done, write_en, write_lut_select, data_in, wr_ack, busy} !== 7'b0 || config_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b config_out=%h, required 0000000 and 0",
               {cen, done, write_en, write_lut_select, data_in, wr_ack, busy}, config_out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, cen} !== 3'b100) begin
      errors++;
      $display("FAIL reset_idle: in_ready/busy/cen=%b, required 100", {in_ready, busy, cen});
    end
  endtask

  task automatic test_stream();
    load_word(40'h01_44_33_22_11, -1, 0);
    check_commit("stream", 33'h1_4433_2211, 4);
  endtask

  task automatic test_stream_gap();
    load_word(40'h01_44_33_22_11, 1, 3);
    check_commit("gap", 33'h1_4433_2211, 7);
  endtask

  task automatic do_write(input string name, input logic sel, input logic dat);
    wr_req = 1'b1; wr_sel = sel; wr_data = dat;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({write_en, wr_ack, write_lut_select, data_in, cen, in_ready} !== {2'b11, sel, dat, 2'b00}) begin
      errors++;
      $display("FAIL %s_issue: we/ack/sel/din/cen/rdy=%b, required %b", name,
               {write_en, wr_ack, write_lut_select, data_in, cen, in_ready}, {2'b11, sel, dat, 2'b00});
    end
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({write_en, wr_ack, write_lut_select, data_in, in_ready, busy} !== 6'b000010) begin
      errors++;
      $display("FAIL %s_release: we/ack/sel/din/rdy/busy=%b, required 000010", name,
               {write_en, wr_ack, write_lut_select, data_in, in_ready, busy});
    end
  endtask

  task automatic test_write();
    do_write("write_upper", 1'b1, 1'b1);
    do_write("write_lower", 1'b0, 1'b1);
    checks++;
    if (config_out !== 33'h1_4433_2211) begin
      errors++;
      $display("FAIL write_keeps_config: config_out=%h, required 1443322 11", config_out);
    end
  endtask

  task automatic test_contention();
    wr_req = 1'b1; wr_sel = 1'b0; wr_data = 1'b1;
    send_beat(8'hAA);
    @(negedge clk);
    checks++;
    if ({write_en, busy, in_ready} !== 3'b011) begin
      errors++;
      $display("FAIL contend_first_beat: we/busy/rdy=%b, required 011", {write_en, busy, in_ready});
    end
    send_beat(8'hBB);
    send_beat(8'hCC);
    send_beat(8'hDD);
    send_beat(8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({cen, write_en} !== 2'b10 || config_out !== 33'h0_DDCC_BBAA) begin
      errors++;
      $display("FAIL contend_commit: cen/we=%b config_out=%h, required 10 and 0ddccbbaa", {cen, write_en}, config_out);
    end
    @(negedge clk);
    checks++;
    if ({cen, write_en, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL contend_idle: cen/we/rdy=%b, required 001", {cen, write_en, in_ready});
    end
    @(negedge clk);
    checks++;
    if ({write_en, wr_ack, write_lut_select, data_in} !== 4'b1101) begin
      errors++;
      $display("FAIL contend_write: we/ack/sel/din=%b, required 1101", {write_en, wr_ack, write_lut_select, data_in});
    end
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({write_en, wr_ack} !== 2'b00) begin
      errors++;
      $display("FAIL contend_write_end: we/ack=%b, required 00", {write_en, wr_ack});
    end
  endtask

  task automatic test_reset_mid_load();
    int c0;
    c0 = cen_cnt;
    send_beat(8'hFF);
    send_beat(8'hFF);
    send_beat(8'hFF);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (config_out !== '0 || {busy, in_ready} !== 2'b01 || cen_cnt !== c0) begin
      errors++;
      $display("FAIL midload_reset: config_out=%h busy/rdy=%b cen pulses=%0d, required 0, 01, 0",
               config_out, {busy, in_ready}, cen_cnt - c0);
    end
    load_word(40'h00_C3_3C_A5_5A, -1, 0);
    check_commit("fresh", 33'h0_C33C_A55A, 4);
    checks++;
    if (cen_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL midload_cen_total: %0d cen pulses, required 1", cen_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    int c0, last_a;
    c0 = cen_cnt;
    send_beat(8'h00); send_beat(8'h00); send_beat(8'h00); send_beat(8'h00);
    send_beat(8'hFF);
    last_a = acc_cyc;
    send_beat(8'h01);
    checks++;
    if (acc_cyc - last_a !== 2) begin
      errors++;
      $display("FAIL b2b_next_beat: accepted %0d edges after final beat, required 2", acc_cyc - last_a);
    end
    checks++;
    if (config_out !== 33'h1_0000_0000) begin
      errors++;
      $display("FAIL b2b_truncate: config_out=%h, required 100000000", config_out);
    end
    send_beat(8'h02); send_beat(8'h03); send_beat(8'h04);
    send_beat(8'hFE);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cen !== 1'b1 || config_out !== 33'h0_0403_0201) begin
      errors++;
      $display("FAIL b2b_second: cen=%b config_out=%h, required 1 and 004030201", cen, config_out);
    end
    @(negedge clk);
    checks++;
    if (cen_cnt - c0 !== 2) begin
      errors++;
      $display("FAIL b2b_cen_count: %0d cen pulses, required 2", cen_cnt - c0);
    end
  endtask

`ifdef LUT_CFG_READBACK_EN
  task automatic test_readback();
    load_word(40'h00_00_00_F0_0F, -1, 0);
    @(negedge clk);
    checks++;
    if (cfg_shadow !== 33'h0_0000_F00F) begin
      errors++;
      $display("FAIL shadow_commit: cfg_shadow=%h, required 00000f00f", cfg_shadow);
    end
    @(negedge clk);
    rd_idx = 4'd5;
    do_write("shadow_wr", 1'b0, 1'b1);
    checks++;
    if (cfg_shadow !== 33'h0_0000_F02F) begin
      errors++;
      $display("FAIL shadow_write: cfg_shadow=%h, required 00000f02f", cfg_shadow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stream_gap();
    test_write();
    test_contention();
    test_reset_mid_load();
    test_back_to_back();
`ifdef LUT_CFG_READBACK_EN
    test_readback();
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
